ocx_tlx_xmt_credit_mgr: RTL and testbench
=========================================

# ocx_tlx_xmt_credit_mgr

Transmit-credit manager for the TLX. Sits directly downstream of the control-flit FSM: it consumes the credit-return fields that FSM extracts from host `return_tl_credits` (VC0, VC3, DCP0, DCP3) and maintains the TLX's available transmit credits. It grants requests from the TLX transmit framer to send one VC0 response or one VC3 command, with up to four data flits. A request is granted only when both the VC credit and the data credits are available.

## Interface
Parameters:
- `VC_CNT_W`, 8: width of the VC0/VC3 credit counters.
- `DCP_CNT_W`, 10: width of the DCP0/DCP3 credit counters.

Ports:
- `tlx_clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high reset.
- `rcv_xmt_credit_vcx0` in 4: returned VC0 credits.
- `rcv_xmt_credit_vcx3` in 4: returned VC3 credits.
- `rcv_xmt_credit_dcpx0` in 6: returned DCP0 credits.
- `rcv_xmt_credit_dcpx3` in 6: returned DCP3 credits.
- `rcv_xmt_credit_tlx_v` in 1: the four return fields are valid this cycle.
- `xmt_req_vc0` in 1: framer requests one VC0 packet.
- `xmt_req_dcp0` in 3: data flits needed with the VC0 request; legal range 0–4.
- `xmt_req_vc3` in 1: framer requests one VC3 packet.
- `xmt_req_dcp3` in 3: data flits needed with the VC3 request; legal range 0–4.
- `xmt_gnt_vc0` out 1: VC0 request granted; credits are consumed this cycle.
- `xmt_gnt_vc3` out 1: VC3 request granted; credits are consumed this cycle.
- `vc0_avail` out `VC_CNT_W`: current VC0 counter.
- `vc3_avail` out `VC_CNT_W`: current VC3 counter.
- `dcp0_avail` out `DCP_CNT_W`: current DCP0 counter.
- `dcp3_avail` out `DCP_CNT_W`: current DCP3 counter.
- `credit_ovf_err` out 1: sticky; a counter saturated on return.
- `req_len_err` out 1: sticky; a request arrived with a DCP value greater than 4.

## Operation
- **Counters:** four counters (VC0, VC3, DCP0, DCP3). All reset to 0. All credit comes from host returns; there is no preload.
- **Eligibility:**
  - `elig0 = xmt_req_vc0 & vc0_avail≥1 & dcp0_avail≥xmt_req_dcp0 & xmt_req_dcp0≤4`.
  - `elig3` uses the same formula with the VC3/DCP3 signals.
- **Arbitration:** one grant per cycle, round-robin.
  - `last_gnt` register; reset value is VC3, so VC0 wins the first contention.
  - Both eligible: grant the VC that is not `last_gnt`.
  - One eligible: grant it.
  - `last_gnt` updates on every grant.
- **Handshake:**
  - The framer holds its request and DCP value stable until granted.
  - The grant is combinational from the registered counters and the current request.
  - The framer drops or changes the request the cycle after the grant.
- **Counter update per edge:** `next = cur + ret − cons`.
  - `ret` is the return field when `rcv_xmt_credit_tlx_v` is high, else 0.
  - `cons` is 1 (VC) or `xmt_req_dcpN` (DCP) when that VC is granted, else 0.
  - Arithmetic is one bit wider than the counter.
  - Result above the max counter value: saturate to all-ones and set `credit_ovf_err`.
  - Underflow cannot occur because grants are gated by the current counter value.
- **Same-cycle return:** a return arriving in the same cycle is not visible to eligibility until the next cycle. A return and a grant on the same counter in the same cycle are both applied.
- **Illegal length:** a request with `xmt_req_dcpN` greater than 4 is never granted and sets `req_len_err`. The other VC continues to arbitrate normally.
- **Reset:** reset mid-operation clears all counters, `last_gnt`, and both error flags in the next cycle. Grants are 0 while `reset` is high.

## Timing
- Grant latency from request: 0 cycles when credits are present.
- Return-to-avail latency: 1 cycle.
- Return-to-grant latency: a request blocked only on credits is granted 1 cycle after `rcv_xmt_credit_tlx_v`.
- Reset values:
  - `xmt_gnt_*` = 0 (combinational, forced low during reset).
  - All `*_avail` = 0.
  - Both error flags = 0.
- No combinational path from the `rcv_xmt_credit_*` inputs to any output.

## Structure
- Shared package (or TLX include): `VC_CNT_W`/`DCP_CNT_W` defaults, the constant `MAX_DCP_PER_PKT = 4`, and the VC-select encoding for `last_gnt` (VC0 = 0, VC3 = 1).
- Sub-module `ocx_tlx_credit_cnt`:
  - Parameterized width; inputs add, sub, add_v.
  - Outputs a saturating count and an overflow pulse.
  - Instantiated four times.
- The top level holds the eligibility logic, the round-robin arbiter, and the sticky error registers.

## Test plan
- **Reset, no returns:** VC0 request with DCP 0 held for 10 cycles → no grant; all avail = 0.
- **Single return then request:**
  - Return VC0 = 2, DCP0 = 4; next cycle VC0 request with DCP 4 → grant that cycle.
  - Next cycle: `vc0_avail` = 1, `dcp0_avail` = 0.
- **Contention:**
  - Setup: VC0 = VC3 = 5, DCP = 20 each; both requests held with DCP 1.
  - Expect grants VC0, VC3, VC0, VC3, VC0, VC3.
  - End state: `vc0_avail` = `vc3_avail` = 2, DCP = 17 each.
- **Data-credit blocking:** VC3 = 3, DCP3 = 2, request DCP 3 → no grant. Return DCP3 = 1 → grant the following cycle, `dcp3_avail` becomes 0.
- **Simultaneous return and consume:** `vc0_avail` = 1; same cycle VC0 granted with DCP 0 and return VC0 = 4 → `vc0_avail` = 4 next cycle.
- **Overflow and illegal length:**
  - Return VC3 = 15 repeatedly with `VC_CNT_W` = 4 → `vc3_avail` holds at 15 and `credit_ovf_err` is set.
  - VC0 request with DCP 5 → never granted and `req_len_err` is set.
  - Both flags cleared by `reset`.

Source files
------------

// File: rtl/ocx_tlx_xmt_credit_mgr_pkg.sv
// Shared constants for the TLX transmit-credit manager: default counter widths,
// return/request field widths, per-packet data-flit limit and VC-select encoding.
package ocx_tlx_xmt_credit_mgr_pkg;

    localparam int VC_CNT_W_DEF    = 8;
    localparam int DCP_CNT_W_DEF   = 10;
    localparam int MAX_DCP_PER_PKT = 4;

    localparam int VC_RET_W  = 4;
    localparam int DCP_RET_W = 6;
    localparam int REQ_DCP_W = 3;

    localparam logic VC_SEL_VC0 = 1'b0;
    localparam logic VC_SEL_VC3 = 1'b1;

    function automatic logic dcp_len_ok(input logic [REQ_DCP_W-1:0] dcp);
        return dcp <= REQ_DCP_W'(MAX_DCP_PER_PKT);
    endfunction

endpackage

// File: rtl/ocx_tlx_credit_cnt.sv
// Saturating credit counter: next = cur + (add if add_v) - sub, clamped to all-ones.
// ovf_o pulses in the cycle whose update would exceed the counter range.
module ocx_tlx_credit_cnt #(
    parameter int CNT_W = 8,
    parameter int ADD_W = 4,
    parameter int SUB_W = 3
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [ADD_W-1:0] add_i,
    input  logic             add_v_i,
    input  logic [SUB_W-1:0] sub_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    // One bit wider than the larger operand so the sum never wraps.
    localparam int SUM_W = ((CNT_W > ADD_W) ? CNT_W : ADD_W) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SUM_W-1:0] sum;

    // sub never exceeds cnt_q because consumption is gated by the current count.
    always_comb begin
        sum   = SUM_W'(cnt_q) + (add_v_i ? SUM_W'(add_i) : '0) - SUM_W'(sub_i);
        ovf_o = sum > SUM_W'({CNT_W{1'b1}});
        cnt_d = ovf_o ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ocx_tlx_xmt_credit_mgr.sv
// TLX transmit-credit manager: tracks VC0/VC3 and DCP0/DCP3 credits returned by the
// host and grants at most one framer request per cycle with round-robin between VCs.
module ocx_tlx_xmt_credit_mgr
    import ocx_tlx_xmt_credit_mgr_pkg::*;
#(
    parameter int VC_CNT_W  = VC_CNT_W_DEF,
    parameter int DCP_CNT_W = DCP_CNT_W_DEF
) (
    input  logic                 tlx_clk,
    input  logic                 reset,
    input  logic [VC_RET_W-1:0]  rcv_xmt_credit_vcx0,
    input  logic [VC_RET_W-1:0]  rcv_xmt_credit_vcx3,
    input  logic [DCP_RET_W-1:0] rcv_xmt_credit_dcpx0,
    input  logic [DCP_RET_W-1:0] rcv_xmt_credit_dcpx3,
    input  logic                 rcv_xmt_credit_tlx_v,
    input  logic                 xmt_req_vc0,
    input  logic [REQ_DCP_W-1:0] xmt_req_dcp0,
    input  logic                 xmt_req_vc3,
    input  logic [REQ_DCP_W-1:0] xmt_req_dcp3,
    output logic                 xmt_gnt_vc0,
    output logic                 xmt_gnt_vc3,
    output logic [VC_CNT_W-1:0]  vc0_avail,
    output logic [VC_CNT_W-1:0]  vc3_avail,
    output logic [DCP_CNT_W-1:0] dcp0_avail,
    output logic [DCP_CNT_W-1:0] dcp3_avail,
    output logic                 credit_ovf_err,
    output logic                 req_len_err
);

    // Index 0 is the VC0 lane, index 1 the VC3 lane.
    logic [1:0][VC_RET_W-1:0]  vc_ret;
    logic [1:0][DCP_RET_W-1:0] dcp_ret;
    logic [1:0][REQ_DCP_W-1:0] req_dcp;
    logic [1:0]                req;
    logic [1:0][VC_CNT_W-1:0]  vc_cnt;
    logic [1:0][DCP_CNT_W-1:0] dcp_cnt;
    logic [1:0]                vc_ovf;
    logic [1:0]                dcp_ovf;
    logic [1:0]                elig;
    logic [1:0]                len_bad;
    logic [1:0]                gnt;

    logic last_gnt_q;
    logic last_gnt_d;
    logic ovf_err_q;
    logic ovf_err_d;
    logic len_err_q;
    logic len_err_d;

    assign vc_ret  = {rcv_xmt_credit_vcx3, rcv_xmt_credit_vcx0};
    assign dcp_ret = {rcv_xmt_credit_dcpx3, rcv_xmt_credit_dcpx0};
    assign req_dcp = {xmt_req_dcp3, xmt_req_dcp0};
    assign req     = {xmt_req_vc3, xmt_req_vc0};

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        ocx_tlx_credit_cnt #(
            .CNT_W (VC_CNT_W),
            .ADD_W (VC_RET_W),
            .SUB_W (1)
        ) u_vc_cnt (
            .clk_i   (tlx_clk),
            .srst_i  (reset),
            .add_i   (vc_ret[gi]),
            .add_v_i (rcv_xmt_credit_tlx_v),
            .sub_i   (gnt[gi]),
            .cnt_o   (vc_cnt[gi]),
            .ovf_o   (vc_ovf[gi])
        );

        ocx_tlx_credit_cnt #(
            .CNT_W (DCP_CNT_W),
            .ADD_W (DCP_RET_W),
            .SUB_W (REQ_DCP_W)
        ) u_dcp_cnt (
            .clk_i   (tlx_clk),
            .srst_i  (reset),
            .add_i   (dcp_ret[gi]),
            .add_v_i (rcv_xmt_credit_tlx_v),
            .sub_i   (gnt[gi] ? req_dcp[gi] : '0),
            .cnt_o   (dcp_cnt[gi]),
            .ovf_o   (dcp_ovf[gi])
        );

        // Eligibility looks only at registered counts, so same-cycle returns are invisible.
        assign elig[gi] = req[gi] & (|vc_cnt[gi])
                        & (dcp_cnt[gi] >= DCP_CNT_W'(req_dcp[gi]))
                        & dcp_len_ok(req_dcp[gi]);
        assign len_bad[gi] = req[gi] & ~dcp_len_ok(req_dcp[gi]);
    end

    always_comb begin
        gnt = '0;
        if (!reset) begin
            if (&elig) begin
                gnt = (last_gnt_q == VC_SEL_VC3) ? 2'b01 : 2'b10;
            end else begin
                gnt = elig;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt[0]) begin
            last_gnt_d = VC_SEL_VC0;
        end else if (gnt[1]) begin
            last_gnt_d = VC_SEL_VC3;
        end
        ovf_err_d = ovf_err_q | (|vc_ovf) | (|dcp_ovf);
        len_err_d = len_err_q | (|len_bad);
    end

    always_ff @(posedge tlx_clk) begin
        if (reset) begin
            last_gnt_q <= VC_SEL_VC3;
            ovf_err_q  <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            ovf_err_q  <= ovf_err_d;
            len_err_q  <= len_err_d;
        end
    end

    assign xmt_gnt_vc0    = gnt[0];
    assign xmt_gnt_vc3    = gnt[1];
    assign vc0_avail      = vc_cnt[0];
    assign vc3_avail      = vc_cnt[1];
    assign dcp0_avail     = dcp_cnt[0];
    assign dcp3_avail     = dcp_cnt[1];
    assign credit_ovf_err = ovf_err_q;
    assign req_len_err    = len_err_q;

endmodule

// File: tb/tb_ocx_tlx_xmt_credit_mgr.sv
// Bench for ocx_tlx_xmt_credit_mgr: directed scenarios followed by random traffic,
// all checked every cycle against an integer credit-ledger model.
module tb_ocx_tlx_xmt_credit_mgr;

    localparam int VW = 4;
    localparam int DW = 6;
    localparam int VC_MAX  = (1 << VW) - 1;
    localparam int DCP_MAX = (1 << DW) - 1;

    logic          tlx_clk = 1'b0;
    logic          reset;
    logic [3:0]    rcv_xmt_credit_vcx0, rcv_xmt_credit_vcx3;
    logic [5:0]    rcv_xmt_credit_dcpx0, rcv_xmt_credit_dcpx3;
    logic          rcv_xmt_credit_tlx_v;
    logic          xmt_req_vc0, xmt_req_vc3;
    logic [2:0]    xmt_req_dcp0, xmt_req_dcp3;
    logic          xmt_gnt_vc0, xmt_gnt_vc3;
    logic [VW-1:0] vc0_avail, vc3_avail;
    logic [DW-1:0] dcp0_avail, dcp3_avail;
    logic          credit_ovf_err, req_len_err;

    ocx_tlx_xmt_credit_mgr #(.VC_CNT_W(VW), .DCP_CNT_W(DW)) dut (
        .tlx_clk              (tlx_clk),
        .reset                (reset),
        .rcv_xmt_credit_vcx0  (rcv_xmt_credit_vcx0),
        .rcv_xmt_credit_vcx3  (rcv_xmt_credit_vcx3),
        .rcv_xmt_credit_dcpx0 (rcv_xmt_credit_dcpx0),
        .rcv_xmt_credit_dcpx3 (rcv_xmt_credit_dcpx3),
        .rcv_xmt_credit_tlx_v (rcv_xmt_credit_tlx_v),
        .xmt_req_vc0          (xmt_req_vc0),
        .xmt_req_dcp0         (xmt_req_dcp0),
        .xmt_req_vc3          (xmt_req_vc3),
        .xmt_req_dcp3         (xmt_req_dcp3),
        .xmt_gnt_vc0          (xmt_gnt_vc0),
        .xmt_gnt_vc3          (xmt_gnt_vc3),
        .vc0_avail            (vc0_avail),
        .vc3_avail            (vc3_avail),
        .dcp0_avail           (dcp0_avail),
        .dcp3_avail           (dcp3_avail),
        .credit_ovf_err       (credit_ovf_err),
        .req_len_err          (req_len_err)
    );

    always #5 tlx_clk = ~tlx_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference ledger: plain integer credit balances plus who was served last.
    int m_vc0, m_vc3, m_dcp0, m_dcp3;
    int m_prefer_vc3;
    bit m_ovf, m_len;
    bit m_g0, m_g3;
    bit obs_g0, obs_g3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_vc0 = 0; m_vc3 = 0; m_dcp0 = 0; m_dcp3 = 0;
        m_prefer_vc3 = 0;
        m_ovf = 0; m_len = 0;
    endtask

    task automatic settle(inout int bal, input int add, input int sub, input int mx);
        int s;
        s = bal + add - sub;
        if (s > mx) begin
            bal   = mx;
            m_ovf = 1;
        end else begin
            bal = s;
        end
    endtask

    task automatic idle();
        rcv_xmt_credit_tlx_v = 0;
        rcv_xmt_credit_vcx0 = 0; rcv_xmt_credit_vcx3 = 0;
        rcv_xmt_credit_dcpx0 = 0; rcv_xmt_credit_dcpx3 = 0;
        xmt_req_vc0 = 0; xmt_req_vc3 = 0;
        xmt_req_dcp0 = 0; xmt_req_dcp3 = 0;
    endtask

    task automatic give(input int v0, input int v3, input int d0, input int d3);
        rcv_xmt_credit_tlx_v = 1;
        rcv_xmt_credit_vcx0 = 4'(v0); rcv_xmt_credit_vcx3 = 4'(v3);
        rcv_xmt_credit_dcpx0 = 6'(d0); rcv_xmt_credit_dcpx3 = 6'(d3);
    endtask

    // One clock: check outputs mid-cycle against the ledger, then advance the ledger.
    task automatic step();
        bit ok0, ok3;
        @(negedge tlx_clk);
        ok0 = xmt_req_vc0 && m_vc0 >= 1 && m_dcp0 >= int'(xmt_req_dcp0) && xmt_req_dcp0 <= 4;
        ok3 = xmt_req_vc3 && m_vc3 >= 1 && m_dcp3 >= int'(xmt_req_dcp3) && xmt_req_dcp3 <= 4;
        m_g0 = 0; m_g3 = 0;
        if (!reset) begin
            if (ok0 && ok3) begin
                if (m_prefer_vc3 == 0) m_g0 = 1; else m_g3 = 1;
            end else begin
                m_g0 = ok0;
                m_g3 = ok3;
            end
        end
        obs_g0 = xmt_gnt_vc0;
        obs_g3 = xmt_gnt_vc3;
        chk("gnt_vc0", xmt_gnt_vc0, m_g0);
        chk("gnt_vc3", xmt_gnt_vc3, m_g3);
        chk("vc0_avail", vc0_avail, m_vc0);
        chk("vc3_avail", vc3_avail, m_vc3);
        chk("dcp0_avail", dcp0_avail, m_dcp0);
        chk("dcp3_avail", dcp3_avail, m_dcp3);
        chk("credit_ovf_err", credit_ovf_err, m_ovf);
        chk("req_len_err", req_len_err, m_len);
        if (m_g0) $display("[%0t] grant VC0 dcp=%0d vc0=%0d dcp0=%0d", $time, xmt_req_dcp0, m_vc0, m_dcp0);
        if (m_g3) $display("[%0t] grant VC3 dcp=%0d vc3=%0d dcp3=%0d", $time, xmt_req_dcp3, m_vc3, m_dcp3);
        if (reset) begin
            model_reset();
        end else begin
            settle(m_vc0,  rcv_xmt_credit_tlx_v ? int'(rcv_xmt_credit_vcx0)  : 0, m_g0 ? 1 : 0, VC_MAX);
            settle(m_vc3,  rcv_xmt_credit_tlx_v ? int'(rcv_xmt_credit_vcx3)  : 0, m_g3 ? 1 : 0, VC_MAX);
            settle(m_dcp0, rcv_xmt_credit_tlx_v ? int'(rcv_xmt_credit_dcpx0) : 0, m_g0 ? int'(xmt_req_dcp0) : 0, DCP_MAX);
            settle(m_dcp3, rcv_xmt_credit_tlx_v ? int'(rcv_xmt_credit_dcpx3) : 0, m_g3 ? int'(xmt_req_dcp3) : 0, DCP_MAX);
            if ((xmt_req_vc0 && xmt_req_dcp0 > 4) || (xmt_req_vc3 && xmt_req_dcp3 > 4)) m_len = 1;
            if (m_g0) m_prefer_vc3 = 1;
            if (m_g3) m_prefer_vc3 = 0;
        end
        @(posedge tlx_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
    endtask

    initial begin
        logic [5:0] seq;
        bit         any_g;
        idle();
        reset = 1;
        model_reset();
        @(posedge tlx_clk); #1;
        @(posedge tlx_clk); #1;
        step();
        reset = 0;

        // No returns yet: a DCP-0 request must starve.
        xmt_req_vc0 = 1; xmt_req_dcp0 = 0;
        any_g = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            any_g |= obs_g0;
        end
        chk("starve_no_gnt", any_g, 0);
        chk("starve_vc0", vc0_avail, 0);
        chk("starve_dcp0", dcp0_avail, 0);

        // Single return then a full-length request.
        idle(); give(2, 0, 4, 0); step();
        idle(); xmt_req_vc0 = 1; xmt_req_dcp0 = 4; step();
        chk("single_gnt", obs_g0, 1);
        idle(); step();
        chk("single_vc0", vc0_avail, 1);
        chk("single_dcp0", dcp0_avail, 0);

        // Contention alternates starting with VC0.
        do_reset();
        idle(); give(5, 5, 20, 20); step();
        idle();
        xmt_req_vc0 = 1; xmt_req_dcp0 = 1;
        xmt_req_vc3 = 1; xmt_req_dcp3 = 1;
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            seq = {seq[4:0], obs_g0};
        end
        chk("cont_seq", seq, 6'b101010);
        idle(); step();
        chk("cont_vc0", vc0_avail, 2);
        chk("cont_vc3", vc3_avail, 2);
        chk("cont_dcp0", dcp0_avail, 17);
        chk("cont_dcp3", dcp3_avail, 17);

        // Data-credit blocking; return unblocks on the following cycle.
        do_reset();
        idle(); give(0, 3, 0, 2); step();
        idle(); xmt_req_vc3 = 1; xmt_req_dcp3 = 3; step();
        chk("dblk_blocked", obs_g3, 0);
        give(0, 0, 0, 1); step();
        chk("dblk_same_cycle", obs_g3, 0);
        idle(); xmt_req_vc3 = 1; xmt_req_dcp3 = 3; step();
        chk("dblk_gnt", obs_g3, 1);
        idle(); step();
        chk("dblk_dcp3", dcp3_avail, 0);
        chk("dblk_vc3", vc3_avail, 2);

        // Same-cycle return and consume on VC0.
        do_reset();
        idle(); give(1, 0, 0, 0); step();
        idle(); xmt_req_vc0 = 1; xmt_req_dcp0 = 0; give(4, 0, 0, 0); step();
        chk("simul_gnt", obs_g0, 1);
        idle(); step();
        chk("simul_vc0", vc0_avail, 4);

        // Saturation and illegal length, then reset clears both flags.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); give(3, 15, 10, 0); step();
        end
        idle(); step();
        chk("sat_vc3", vc3_avail, 15);
        chk("sat_flag", credit_ovf_err, 1);
        xmt_req_vc0 = 1; xmt_req_dcp0 = 5;
        xmt_req_vc3 = 1; xmt_req_dcp3 = 0;
        any_g = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            any_g |= obs_g0;
        end
        chk("len_no_gnt", any_g, 0);
        chk("len_flag", req_len_err, 1);
        idle(); do_reset(); step();
        chk("clr_ovf", credit_ovf_err, 0);
        chk("clr_len", req_len_err, 0);

        // Random traffic: requests held until granted, illegal ones eventually withdrawn.
        idle();
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            rcv_xmt_credit_tlx_v = ($urandom_range(0, 2) == 0);
            rcv_xmt_credit_vcx0  = 4'($urandom_range(0, 3));
            rcv_xmt_credit_vcx3  = 4'($urandom_range(0, 3));
            rcv_xmt_credit_dcpx0 = 6'($urandom_range(0, 8));
            rcv_xmt_credit_dcpx3 = 6'($urandom_range(0, 8));
            if (m_g0 || !xmt_req_vc0 || (xmt_req_dcp0 > 4 && $urandom_range(0, 3) == 0)) begin
                xmt_req_vc0  = 1'($urandom_range(0, 1));
                xmt_req_dcp0 = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            end
            if (m_g3 || !xmt_req_vc3 || (xmt_req_dcp3 > 4 && $urandom_range(0, 3) == 0)) begin
                xmt_req_vc3  = 1'($urandom_range(0, 1));
                xmt_req_dcp3 = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
